// File: rtl/cosim_log_drain_sched_pkg.sv
// Shared types for the co-simulation commit-log drain scheduler: DPI word layout,
// log kinds, the stream item record and the scheduler FSM encoding.
package cosim_log_drain_sched_pkg;

  typedef logic [31:0] dpi_word_t;

  localparam int unsigned LOG_REG_WRITE_ITEM_DPI_WORDS = 3;
  localparam int unsigned LOG_MEM_ITEM_DPI_WORDS       = 4;
  localparam int unsigned ITEM_WORDS =
      (LOG_REG_WRITE_ITEM_DPI_WORDS > LOG_MEM_ITEM_DPI_WORDS) ?
      LOG_REG_WRITE_ITEM_DPI_WORDS : LOG_MEM_ITEM_DPI_WORDS;

  typedef enum logic [1:0] {
    LogRegWr = 2'd0,
    LogMemRd = 2'd1,
    LogMemWr = 2'd2
  } log_kind_e;

  typedef dpi_word_t [LOG_REG_WRITE_ITEM_DPI_WORDS-1:0] reg_wr_item_t;
  typedef dpi_word_t [LOG_MEM_ITEM_DPI_WORDS-1:0]       mem_item_t;
  typedef dpi_word_t [ITEM_WORDS-1:0]                   item_data_t;

  typedef struct packed {
    log_kind_e   kind;
    logic [31:0] idx;
    item_data_t  data;
  } log_item_t;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDrain,
    StAdvance,
    StDone
  } drain_state_e;

  function automatic logic [31:0] clamp_count(logic [31:0] raw, logic [31:0] lim);
    return (raw > lim) ? lim : raw;
  endfunction

endpackage

// File: rtl/cosim_log_fetch.sv
// Selects one of the three commit-log getters by kind, zero-pads its payload to the common
// item width and reports the clamped list length plus an overflow flag.
module cosim_log_fetch
  import cosim_log_drain_sched_pkg::*;
#(
  parameter int unsigned MAX_ITEMS = 64,
  parameter int unsigned PROC_W    = 1
) (
  input  logic              fetch_i,
  input  log_kind_e         kind_i,
  input  logic [PROC_W-1:0] proc_i,
  input  logic [31:0]       rd_idx_i,
  output logic              get_reg_wr_o,
  output logic              get_mem_rd_o,
  output logic              get_mem_wr_o,
  output logic [PROC_W-1:0] get_proc_o,
  output logic [31:0]       get_idx_o,
  input  logic [31:0]       reg_wr_cnt_i,
  input  logic [31:0]       mem_rd_cnt_i,
  input  logic [31:0]       mem_wr_cnt_i,
  input  reg_wr_item_t      reg_wr_item_i,
  input  mem_item_t         mem_rd_item_i,
  input  mem_item_t         mem_wr_item_i,
  output logic [31:0]       cnt_o,
  output logic              overflow_o,
  output item_data_t        data_o
);

  logic [31:0] raw_cnt;

  always_comb begin
    raw_cnt      = '0;
    data_o       = '0;
    get_reg_wr_o = 1'b0;
    get_mem_rd_o = 1'b0;
    get_mem_wr_o = 1'b0;
    unique case (kind_i)
      LogRegWr: begin
        get_reg_wr_o = fetch_i;
        raw_cnt      = reg_wr_cnt_i;
        data_o[LOG_REG_WRITE_ITEM_DPI_WORDS-1:0] = reg_wr_item_i;
      end
      LogMemRd: begin
        get_mem_rd_o = fetch_i;
        raw_cnt      = mem_rd_cnt_i;
        data_o[LOG_MEM_ITEM_DPI_WORDS-1:0] = mem_rd_item_i;
      end
      LogMemWr: begin
        get_mem_wr_o = fetch_i;
        raw_cnt      = mem_wr_cnt_i;
        data_o[LOG_MEM_ITEM_DPI_WORDS-1:0] = mem_wr_item_i;
      end
      default: ;
    endcase
    cnt_o      = clamp_count(raw_cnt, 32'(MAX_ITEMS));
    overflow_o = fetch_i && (raw_cnt > 32'(MAX_ITEMS));
  end

  assign get_proc_o = proc_i;
  assign get_idx_o  = rd_idx_i;

endmodule

// File: rtl/cosim_log_drain_sched.sv
// Walks every processor's reg-write, mem-read and mem-write commit logs after a co-simulated
// step and streams the items one per valid/ready handshake to the cosim comparator.
module cosim_log_drain_sched
  import cosim_log_drain_sched_pkg::*;
#(
  parameter int unsigned NUM_PROCS = 1,
  parameter int unsigned MAX_ITEMS = 64,
  parameter int unsigned PROC_W    = (NUM_PROCS > 1) ? $clog2(NUM_PROCS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              item_valid_o,
  input  logic              item_ready_i,
  output log_kind_e         item_kind_o,
  output logic [PROC_W-1:0] item_proc_o,
  output logic [31:0]       item_idx_o,
  output item_data_t        item_data_o,
  output logic              overflow_o,
  output logic [31:0]       items_sent_o,
  // Getter call sites: one strobe per kind, shared processor and buffer read index.
  output logic              get_reg_wr_o,
  output logic              get_mem_rd_o,
  output logic              get_mem_wr_o,
  output logic [PROC_W-1:0] get_proc_o,
  output logic [31:0]       get_idx_o,
  input  logic [31:0]       reg_wr_cnt_i,
  input  logic [31:0]       mem_rd_cnt_i,
  input  logic [31:0]       mem_wr_cnt_i,
  input  reg_wr_item_t      reg_wr_item_i,
  input  mem_item_t         mem_rd_item_i,
  input  mem_item_t         mem_wr_item_i
);

  drain_state_e      state_q, state_d;
  logic              launch_q, launch_d;
  logic [PROC_W-1:0] proc_q, proc_d;
  log_item_t         item_q, item_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              overflow_q, overflow_d;
  logic [31:0]       sent_q, sent_d;

  logic              fetch_call;
  logic [31:0]       rd_idx;
  logic [31:0]       fetch_cnt;
  logic              fetch_ovf;
  item_data_t        fetch_data;

  // Never call a getter in a reset cycle.
  assign fetch_call = (state_q == StFetch) && !rst_i;
  // In DRAIN the buffer is read one ahead so the next item can be registered on a handshake.
  assign rd_idx     = (state_q == StFetch) ? 32'd0 : item_q.idx + 32'd1;

  cosim_log_fetch #(
    .MAX_ITEMS (MAX_ITEMS),
    .PROC_W    (PROC_W)
  ) u_fetch (
    .fetch_i       (fetch_call),
    .kind_i        (item_q.kind),
    .proc_i        (proc_q),
    .rd_idx_i      (rd_idx),
    .get_reg_wr_o  (get_reg_wr_o),
    .get_mem_rd_o  (get_mem_rd_o),
    .get_mem_wr_o  (get_mem_wr_o),
    .get_proc_o    (get_proc_o),
    .get_idx_o     (get_idx_o),
    .reg_wr_cnt_i  (reg_wr_cnt_i),
    .mem_rd_cnt_i  (mem_rd_cnt_i),
    .mem_wr_cnt_i  (mem_wr_cnt_i),
    .reg_wr_item_i (reg_wr_item_i),
    .mem_rd_item_i (mem_rd_item_i),
    .mem_wr_item_i (mem_wr_item_i),
    .cnt_o         (fetch_cnt),
    .overflow_o    (fetch_ovf),
    .data_o        (fetch_data)
  );

  always_comb begin
    state_d    = state_q;
    launch_d   = launch_q;
    proc_d     = proc_q;
    item_d     = item_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    overflow_d = overflow_q;
    sent_d     = sent_q;
    case (state_q)
      // An accepted start arms launch_q for one cycle (already busy) before the first fetch.
      StIdle: begin
        if (launch_q) begin
          launch_d = 1'b0;
          state_d  = StFetch;
        end else if (start_i) begin
          launch_d    = 1'b1;
          sent_d      = '0;
          proc_d      = '0;
          item_d.kind = LogRegWr;
        end
      end
      StFetch: begin
        item_d.idx = '0;
        cnt_d      = fetch_cnt;
        if (fetch_ovf) overflow_d = 1'b1;
        if (fetch_cnt != '0) begin
          valid_d     = 1'b1;
          item_d.data = fetch_data;
          state_d     = StDrain;
        end else begin
          state_d = StAdvance;
        end
      end
      StDrain: begin
        if (item_ready_i) begin
          sent_d = sent_q + 32'd1;
          if (item_q.idx == cnt_q - 32'd1) begin
            valid_d = 1'b0;
            state_d = StAdvance;
          end else begin
            item_d.idx  = item_q.idx + 32'd1;
            item_d.data = fetch_data;
          end
        end
      end
      StAdvance: begin
        if (item_q.kind != LogMemWr) begin
          item_d.kind = log_kind_e'(item_q.kind + 2'd1);
          state_d     = StFetch;
        end else if (proc_q != PROC_W'(NUM_PROCS - 1)) begin
          proc_d      = proc_q + PROC_W'(1);
          item_d.kind = LogRegWr;
          state_d     = StFetch;
        end else begin
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      launch_q   <= 1'b0;
      proc_q     <= '0;
      item_q     <= '0;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      sent_q     <= '0;
    end else begin
      state_q    <= state_d;
      launch_q   <= launch_d;
      proc_q     <= proc_d;
      item_q     <= item_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      sent_q     <= sent_d;
    end
  end

  assign busy_o       = launch_q || (state_q == StFetch) || (state_q == StDrain) ||
                        (state_q == StAdvance);
  assign done_o       = (state_q == StDone);
  assign item_valid_o = valid_q;
  assign item_kind_o  = item_q.kind;
  assign item_proc_o  = proc_q;
  assign item_idx_o   = item_q.idx;
  assign item_data_o  = item_q.data;
  assign overflow_o   = overflow_q;
  assign items_sent_o = sent_q;

endmodule

// File: tb/tb_cosim_log_drain_sched.sv
// Randomised bench for the commit-log drain scheduler: a C-side log model feeds the getters and
// a per-cycle timeline model predicts every stream beat, busy/done pulse and counter.
module tb_cosim_log_drain_sched;
  import cosim_log_drain_sched_pkg::*;

  localparam int NP   = 2;
  localparam int MI   = 64;
  localparam int MAXC = 8192;

  typedef struct {
    bit          en;
    bit          valid;
    bit          busy;
    bit          done;
    bit          ovf;
    logic [31:0] sent;
    int          kind;
    int          proc;
    int          idx;
    logic [127:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_i, start_i, item_ready_i;
  logic         busy_o, done_o, item_valid_o, overflow_o;
  log_kind_e    item_kind_o;
  logic [0:0]   item_proc_o, get_proc;
  logic [31:0]  item_idx_o, items_sent_o, get_idx;
  item_data_t   item_data_o;
  logic         get_rw, get_mr, get_mw;
  logic [31:0]  rw_cnt, mr_cnt, mw_cnt;
  reg_wr_item_t rw_item;
  mem_item_t    mr_item, mw_item;

  int unsigned  cnts [NP][3];
  logic [31:0]  seed;
  bit           rdy_tab [MAXC];
  exp_t         ex [MAXC];
  int           cyc, total, bad;
  int           m_sent, obs_hs, obs_busy, obs_done, obs_gets, obs_last_idx;
  bit           m_ovf;

  cosim_log_drain_sched #(
    .NUM_PROCS (NP),
    .MAX_ITEMS (MI)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .item_valid_o  (item_valid_o),
    .item_ready_i  (item_ready_i),
    .item_kind_o   (item_kind_o),
    .item_proc_o   (item_proc_o),
    .item_idx_o    (item_idx_o),
    .item_data_o   (item_data_o),
    .overflow_o    (overflow_o),
    .items_sent_o  (items_sent_o),
    .get_reg_wr_o  (get_rw),
    .get_mem_rd_o  (get_mr),
    .get_mem_wr_o  (get_mw),
    .get_proc_o    (get_proc),
    .get_idx_o     (get_idx),
    .reg_wr_cnt_i  (rw_cnt),
    .mem_rd_cnt_i  (mr_cnt),
    .mem_wr_cnt_i  (mw_cnt),
    .reg_wr_item_i (rw_item),
    .mem_rd_item_i (mr_item),
    .mem_wr_item_i (mw_item)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] payload(int p, int k, int i, int w, logic [31:0] sd);
    return {4'(p), 4'(k), 4'(w), 4'h5, 16'(i)} ^ sd;
  endfunction

  // Expected stream payload: reg-write items carry three words, the fourth reads as zero.
  function automatic logic [127:0] exp_data(int p, int k, int i, logic [31:0] sd);
    logic [127:0] r = '0;
    for (int w = 0; w < 4; w++)
      if (!(k == 0 && w == 3)) r[w*32 +: 32] = payload(p, k, i, w, sd);
    return r;
  endfunction

  // C-side log buffers as seen through the getters.
  always_comb begin
    rw_cnt = cnts[get_proc][0];
    mr_cnt = cnts[get_proc][1];
    mw_cnt = cnts[get_proc][2];
    for (int w = 0; w < 3; w++) rw_item[w] = payload(int'(get_proc), 0, int'(get_idx), w, seed);
    for (int w = 0; w < 4; w++) begin
      mr_item[w] = payload(int'(get_proc), 1, int'(get_idx), w, seed);
      mw_item[w] = payload(int'(get_proc), 2, int'(get_idx), w, seed);
    end
  end

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, a, e);
    end
  endtask

  task automatic put(input int c, input bit v, input bit b, input bit dn,
                     input int k, input int p, input int i);
    ex[c].en    = 1'b1;
    ex[c].valid = v;
    ex[c].busy  = b;
    ex[c].done  = dn;
    ex[c].ovf   = m_ovf;
    ex[c].sent  = 32'(m_sent);
    ex[c].kind  = k;
    ex[c].proc  = p;
    ex[c].idx   = i;
    ex[c].data  = v ? exp_data(p, k, i, seed) : '0;
  endtask

  // Timeline of one drain started in cycle s: launch, then per list fetch, beats, advance.
  task automatic plan(input int s, output int d);
    int t, n;
    bit hs;
    put(s, 0, 0, 0, 0, 0, 0);
    m_sent = 0;
    put(s + 1, 0, 1, 0, 0, 0, 0);
    t = s + 2;
    for (int p = 0; p < NP; p++) begin
      for (int k = 0; k < 3; k++) begin
        n = int'(cnts[p][k]);
        put(t, 0, 1, 0, 0, 0, 0);
        t++;
        if (n > MI) begin
          m_ovf = 1'b1;
          n = MI;
        end
        for (int i = 0; i < n; i++) begin
          hs = 1'b0;
          while (!hs) begin
            if (t >= MAXC - 8) begin
              $display("FAIL plan_bound cyc=%0d got=%0d want<%0d", cyc, t, MAXC - 8);
              $fatal(1);
            end
            put(t, 1, 1, 0, k, p, i);
            hs = rdy_tab[t];
            t++;
          end
          m_sent++;
        end
        put(t, 0, 1, 0, 0, 0, 0);
        t++;
      end
    end
    put(t, 0, 0, 1, 0, 0, 0);
    d = t;
    for (int j = 1; j <= 3; j++) put(t + j, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic fill_rdy(input int s, input int mode);
    logic [3:0] pat = 4'b1001;
    for (int c = s + 1; c < MAXC; c++) begin
      case (mode)
        0:       rdy_tab[c] = 1'b1;
        1:       rdy_tab[c] = pat[3 - ((c - s) % 4)];
        default: rdy_tab[c] = ($urandom % 4) != 0;
      endcase
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_counts(input int a0, b0, c0, a1, b1, c1);
    cnts[0][0] = a0; cnts[0][1] = b0; cnts[0][2] = c0;
    cnts[1][0] = a1; cnts[1][1] = b1; cnts[1][2] = c1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, 128'(busy_o), 0);
    chk({tag, "_done"}, 128'(done_o), 0);
    chk({tag, "_valid"}, 128'(item_valid_o), 0);
    chk({tag, "_ovf"}, 128'(overflow_o), 0);
    chk({tag, "_sent"}, 128'(items_sent_o), 0);
    chk({tag, "_idx"}, 128'(item_idx_o), 0);
    chk({tag, "_proc"}, 128'(item_proc_o), 0);
    chk({tag, "_kind"}, 128'(item_kind_o), 0);
    chk({tag, "_data"}, 128'(item_data_o), 0);
  endtask

  // One full drain; a second start pulse lands mid-drain when extra is set.
  task automatic drain(input int mode, input bit extra, output int s, output int d,
                       output int hs, output int bsy);
    int h0, b0, g0;
    s = cyc;
    h0 = obs_hs;
    b0 = obs_busy;
    g0 = obs_gets;
    fill_rdy(s, mode);
    plan(s, d);
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    if (extra) begin
      wait_cyc(s + 3);
      start_i = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
    end
    wait_cyc(d + 3);
    hs  = obs_hs - h0;
    bsy = obs_busy - b0;
    chk("getter_calls", 128'(obs_gets - g0), 128'(3 * NP));
  endtask

  initial begin
    int s, d, hs, bsy;
    rst_i = 1'b1; start_i = 1'b0; item_ready_i = 1'b0;
    cyc = 0; total = 0; bad = 0; m_sent = 0; m_ovf = 1'b0; seed = 32'h1234_abcd;
    obs_hs = 0; obs_busy = 0; obs_done = -1; obs_gets = 0; obs_last_idx = -1;
    set_counts(0, 0, 0, 0, 0, 0);
    for (int c = 0; c < MAXC; c++) begin
      ex[c].en = 1'b0;
      rdy_tab[c] = 1'b0;
    end
    fork
      forever begin
        @(posedge clk);
        cyc++;
        #1;
        if (cyc < MAXC) item_ready_i = rdy_tab[cyc];
      end
      forever begin
        @(negedge clk);
        if (item_valid_o && item_ready_i) begin
          obs_hs++;
          obs_last_idx = int'(item_idx_o);
        end
        if (busy_o) obs_busy++;
        if (done_o) obs_done = cyc;
        if (get_rw || get_mr || get_mw) obs_gets++;
        if (cyc < MAXC && ex[cyc].en) begin
          chk("valid", 128'(item_valid_o), 128'(ex[cyc].valid));
          chk("busy", 128'(busy_o), 128'(ex[cyc].busy));
          chk("done", 128'(done_o), 128'(ex[cyc].done));
          chk("sent", 128'(items_sent_o), 128'(ex[cyc].sent));
          chk("overflow", 128'(overflow_o), 128'(ex[cyc].ovf));
          if (ex[cyc].valid) begin
            chk("kind", 128'(item_kind_o), 128'(ex[cyc].kind));
            chk("proc", 128'(item_proc_o), 128'(ex[cyc].proc));
            chk("idx", 128'(item_idx_o), 128'(ex[cyc].idx));
            chk("data", 128'(item_data_o), ex[cyc].data);
          end
        end
      end
      begin
        wait_cyc(3);
        chk_reset("por");
        rst_i = 1'b0;
        wait_cyc(cyc + 1);

        // Two reg-writes and one mem-write on hart 0, ready held high.
        set_counts(2, 0, 1, 0, 0, 0);
        drain(0, 1'b0, s, d, hs, bsy);
        chk("s1_done_lat", 128'(obs_done - s), 17);
        chk("s1_beats", 128'(hs), 3);
        chk("s1_sent", 128'(items_sent_o), 3);

        // Same logs, ready 1-0-0-1.
        seed = $urandom;
        drain(1, 1'b0, s, d, hs, bsy);
        chk("s2_beats", 128'(hs), 3);
        chk("s2_sent", 128'(items_sent_o), 3);

        // All lists empty.
        set_counts(0, 0, 0, 0, 0, 0);
        drain(0, 1'b0, s, d, hs, bsy);
        chk("empty_done_lat", 128'(obs_done - s), 14);
        chk("empty_busy", 128'(bsy), 13);
        chk("empty_beats", 128'(hs), 0);

        // 70 reg-writes clamp to 64 and set the sticky overflow.
        set_counts(70, 0, 0, 0, 0, 0);
        drain(0, 1'b0, s, d, hs, bsy);
        chk("ovf_beats", 128'(hs), 64);
        chk("ovf_last_idx", 128'(obs_last_idx), 63);
        chk("ovf_set", 128'(overflow_o), 1);
        set_counts(1, 1, 1, 1, 1, 1);
        drain(1, 1'b0, s, d, hs, bsy);
        chk("ovf_sticky", 128'(overflow_o), 1);
        chk("ovf_next_beats", 128'(hs), 6);

        // Reset while hart 0's 10-item list is at idx 5.
        set_counts(10, 0, 0, 0, 0, 0);
        s = cyc;
        fill_rdy(s, 0);
        plan(s, d);
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        wait_cyc(s + 8);
        rst_i = 1'b1;
        for (int c = s + 9; c <= d + 3; c++) ex[c].en = 1'b0;
        @(posedge clk);
        #1;
        chk_reset("midrst");
        rst_i = 1'b0;
        m_sent = 0;
        m_ovf = 1'b0;
        drain(0, 1'b0, s, d, hs, bsy);
        chk("rst_restart_beats", 128'(hs), 10);
        chk("rst_restart_last", 128'(obs_last_idx), 9);

        // A start pulse while busy must not disturb the run.
        set_counts(2, 0, 1, 0, 0, 0);
        drain(0, 1'b1, s, d, hs, bsy);
        chk("dbl_done_lat", 128'(obs_done - s), 17);
        chk("dbl_sent", 128'(items_sent_o), 3);

        for (int r = 0; r < 6; r++) begin
          seed = $urandom;
          for (int p = 0; p < NP; p++)
            for (int k = 0; k < 3; k++)
              cnts[p][k] = (($urandom % 8) == 0) ? 65 + ($urandom % 6) : ($urandom % 10);
          drain(2, r[0], s, d, hs, bsy);
          chk("rand_sent", 128'(items_sent_o), 128'(m_sent));
        end
      end
    join_any
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cosim_log_drain_sched.md
Name: cosim_log_drain_sched

Overview:
- Simulation-side scheduler that collects per-processor commit logs from the C model after each co-simulated step.
- Uses the private DPI getters for register writes, memory reads and memory writes.
- Delivers the log items one per handshake on a valid/ready stream to the cosim comparator.
- Visits processors in ascending order, kinds in fixed order: reg-write, mem-read, mem-write.
- Owns the only call sites of the private getters.

Parameters:
- NUM_PROCS, 1, number of simulated harts; processor index range 0..NUM_PROCS-1.
- MAX_ITEMS, 64, per-kind, per-processor local buffer depth; larger counts are clamped.
- PROC_W, $clog2(NUM_PROCS) min 1, width of the processor index.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle pulse: drain the logs of all processors.
- busy_o  out  1  high from the cycle after an accepted start until done_o.
- done_o  out  1  one-cycle pulse when the drain completes.
- item_valid_o  out  1  item on the stream is valid.
- item_ready_i  in  1  consumer accepts the item.
- item_kind_o  out  2  log_kind_e: 0 REG_WR, 1 MEM_RD, 2 MEM_WR.
- item_proc_o  out  PROC_W  source processor.
- item_idx_o  out  32  item index within its kind list.
- item_data_o  out  ITEM_WORDS x dpi_word_t  item payload; unused upper words are zero.
- overflow_o  out  1  sticky: some list exceeded MAX_ITEMS.
- items_sent_o  out  32  handshakes completed since the last accepted start.

Behaviour:
- Reset values: busy_o, done_o, item_valid_o, overflow_o = 0. items_sent_o, item_idx_o, item_proc_o, item_kind_o, item_data_o = 0. FSM = IDLE.
- FSM states: IDLE, FETCH, DRAIN, ADVANCE, DONE.
- IDLE:
  - start_i=1 → clear items_sent_o; proc=0, kind=REG_WR; go to FETCH.
  - start_i is ignored in every state other than IDLE.
- FETCH (exactly 1 cycle):
  - Call the getter for (kind, proc) into a MAX_ITEMS-deep buffer.
  - cnt = min(inserted_elements, MAX_ITEMS); if inserted_elements > MAX_ITEMS, set overflow_o.
  - Latch cnt; idx=0.
  - cnt==0 → ADVANCE; otherwise → DRAIN.
- DRAIN:
  - item_valid_o=1; item_* driven from buffer[idx], registered, stable while valid && !ready.
  - On a handshake: items_sent_o++.
  - idx==cnt-1 → ADVANCE, with item_valid_o low next cycle; otherwise idx++ and the next item is presented the next cycle.
  - Throughput: 1 item/cycle with ready held high.
- ADVANCE (1 cycle):
  - kind<MEM_WR → kind++, then FETCH.
  - Else proc<NUM_PROCS-1 → proc++, kind=REG_WR, then FETCH.
  - Else → DONE.
- DONE: done_o=1 for one cycle, busy_o drops in the same cycle; → IDLE.
- Latency for an all-empty drain: start to done_o = 1 + 6*NUM_PROCS + 1 cycles.
- item_valid_o never depends combinationally on item_ready_i.
- Reset mid-operation: return to IDLE immediately, drop buffered items, make no DPI call in the reset cycle. overflow_o is cleared only by reset.
- items_sent_o wraps modulo 2^32.

Decomposition:
- cosim_constants_pkg holds:
  - ITEM_WORDS = max(LOG_REG_WRITE_ITEM_DPI_WORDS, LOG_MEM_ITEM_DPI_WORDS).
  - log_kind_e.
- log_item_t goes to basic_types_pkg: kind, proc, idx, data.
- Sub-module cosim_log_fetch: wraps the three getters behind a kind select, zero-pads the payload to ITEM_WORDS, and returns the clamped count plus the overflow flag. FSM and stream stay in the top module.

Test Plan:
- NUM_PROCS=1; C side logs 2 reg-writes, 0 mem-rd, 1 mem-wr; ready always 1 → 3 beats: kinds 0,0,2 with idx 0,1,0; done_o 2+6+1... exact cycle checked against the model; items_sent_o=3.
- Same stimulus, ready toggling 1-0-0-1 → each payload held stable while stalled; no item lost or duplicated; item order unchanged.
- NUM_PROCS=2, all logs empty → no valid; done_o exactly 14 cycles after start; busy_o high for 13 cycles.
- C side logs 70 reg-writes with MAX_ITEMS=64 → 64 beats (idx 0..63); overflow_o=1 and stays 1 through the next start.
- rst_i asserted in DRAIN at idx 5 of 10 → next cycle all outputs at reset values; a new start re-fetches and begins at idx 0.
- start_i pulsed while busy → ignored; item count and done_o timing match the single-start run.
